qdr_port_arbiter: RTL and testbench

- Shares one QDR controller master interface between NUM_PORTS fabric requesters, using round-robin arbitration.
- Tracks outstanding reads in an in-order tag FIFO and routes each returning master_rd_dvld to the port that issued the read.
- Sits between user fabric ports and the QDR sniffer slave interface.
- Registers the master-side command for timing.

---
 rtl/qdr_arb_pkg.sv | 21 ++
 rtl/qdr_tag_fifo.sv | 54 +++++
 rtl/qdr_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_qdr_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_arb_pkg.sv
// Shared definitions for the QDR port arbiter: port index type and helpers.
package qdr_arb_pkg;

  // Index width is sized for the largest legal port count (4), so one
  // package serves every NUM_PORTS configuration of the arbiter.
  localparam int MAX_PORTS  = 4;
  localparam int PORT_IDX_W = $clog2(MAX_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Converts a one-hot grant vector into the index of its set bit.
  function automatic port_idx_t onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | port_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/qdr_tag_fifo.sv
// In-order tag FIFO remembering which port issued each outstanding read.
module qdr_tag_fifo
  import qdr_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     qdr_clk,
  input  logic                     qdr_rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  port_idx_t                din_i,
  output port_idx_t                dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  port_idx_t     mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Pointer MSB acts as a lap bit so full and empty are distinguishable.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_o  = wr_ptr_q - rd_ptr_q;
    dout_o   = mem_q[rd_ptr_q[AW-1:0]];
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge qdr_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/qdr_port_arbiter.sv
// Round-robin arbiter sharing one QDR master interface between fabric ports,
// with a registered command stage and read-return routing by tag FIFO.
module qdr_port_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int QDR_ADDR_WIDTH = 21,
  parameter int QDR_DATA_WIDTH = 36,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int RD_FIFO_DEPTH  = 16
) (
  input  logic                                  qdr_clk,
  input  logic                                  qdr_rst_n,
  input  logic [NUM_PORTS*32-1:0]               port_addr,
  input  logic [NUM_PORTS-1:0]                  port_wr_strb,
  input  logic [NUM_PORTS*2*QDR_DATA_WIDTH-1:0] port_wr_data,
  input  logic [NUM_PORTS*2*QDR_BW_WIDTH-1:0]   port_wr_be,
  input  logic [NUM_PORTS-1:0]                  port_rd_strb,
  output logic [NUM_PORTS-1:0]                  port_ack,
  output logic [2*QDR_DATA_WIDTH-1:0]           port_rd_data,
  output logic [NUM_PORTS-1:0]                  port_rd_dvld,
  output logic [QDR_ADDR_WIDTH-1:0]             master_addr,
  output logic                                  master_wr_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]           master_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]             master_wr_be,
  output logic                                  master_rd_strb,
  input  logic [2*QDR_DATA_WIDTH-1:0]           master_rd_data,
  input  logic                                  master_rd_dvld,
  input  logic                                  master_ack,
  output logic [$clog2(RD_FIFO_DEPTH):0]        rd_outstanding,
  output logic                                  err_orphan
);

  localparam int AW  = $clog2(RD_FIFO_DEPTH);
  localparam int DW2 = 2 * QDR_DATA_WIDTH;
  localparam int BW2 = 2 * QDR_BW_WIDTH;

  logic                      active_q;
  port_idx_t                 rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]      eligible;
  logic [NUM_PORTS-1:0]      grant;
  logic [MAX_PORTS-1:0]      grant_ext;
  logic                      found;
  logic                      accept;
  port_idx_t                 grant_idx;

  logic [QDR_ADDR_WIDTH-1:0] sel_addr;
  logic [DW2-1:0]            sel_wr_data;
  logic [BW2-1:0]            sel_wr_be;
  logic                      sel_wr_strb;
  logic                      sel_rd_strb;

  logic [QDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW2-1:0]            wr_data_q, wr_data_d;
  logic [BW2-1:0]            wr_be_q, wr_be_d;
  logic                      wr_strb_q, wr_strb_d;
  logic                      rd_strb_q, rd_strb_d;
  logic                      err_orphan_q, err_orphan_d;

  logic                      fifo_push, fifo_pop;
  logic                      fifo_full, fifo_empty;
  port_idx_t                 fifo_dout;
  logic [AW:0]               fifo_count;

  // Upper address bits beyond the QDR address width are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^port_addr;

  // Grants are held off until the first clock after reset release so that
  // port_ack is 0 for the whole time reset is asserted.
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) active_q <= 1'b0;
    else            active_q <= 1'b1;
  end

  // Eligibility: any strobe with controller ready; reads (including combined
  // read+write) are blocked while every tag slot is in use.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = active_q && master_ack &&
                    (port_wr_strb[i] || port_rd_strb[i]) &&
                    !(port_rd_strb[i] && fifo_full);
    end
  end

  // Round-robin search from rr_ptr, ascending with wrap; first eligible wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && eligible[i] &&
            (((int'(rr_ptr_q) + k) % NUM_PORTS) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Grant index, selected command fields and round-robin pointer update.
  always_comb begin
    grant_ext                  = '0;
    grant_ext[NUM_PORTS-1:0]   = grant;
    grant_idx                  = onehot_to_idx(grant_ext);
    accept                     = |grant;
    sel_addr                   = '0;
    sel_wr_data                = '0;
    sel_wr_be                  = '0;
    sel_wr_strb                = 1'b0;
    sel_rd_strb                = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_addr    = sel_addr    | port_addr[32*i +: QDR_ADDR_WIDTH];
        sel_wr_data = sel_wr_data | port_wr_data[DW2*i +: DW2];
        sel_wr_be   = sel_wr_be   | port_wr_be[BW2*i +: BW2];
        sel_wr_strb = sel_wr_strb | port_wr_strb[i];
        sel_rd_strb = sel_rd_strb | port_rd_strb[i];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (grant_idx == port_idx_t'(NUM_PORTS - 1)) rr_ptr_d = '0;
      else                                         rr_ptr_d = port_idx_t'(grant_idx + 1'b1);
    end
  end

  // Command register next state: strobes pulse for one cycle, fields hold.
  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    wr_strb_d = 1'b0;
    rd_strb_d = 1'b0;
    if (accept) begin
      addr_d    = sel_addr;
      wr_data_d = sel_wr_data;
      wr_be_d   = sel_wr_be;
      wr_strb_d = sel_wr_strb;
      rd_strb_d = sel_rd_strb;
    end
  end

  // Registered command, arbitration pointer and sticky orphan flag.
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      rr_ptr_q     <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      wr_strb_q    <= 1'b0;
      rd_strb_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      wr_strb_q    <= wr_strb_d;
      rd_strb_q    <= rd_strb_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Read return routing: a return pops the oldest tag and flags its port;
  // a return with nothing outstanding is dropped and latched as an orphan.
  always_comb begin
    fifo_push    = accept && sel_rd_strb;
    fifo_pop     = master_rd_dvld && !fifo_empty;
    err_orphan_d = err_orphan_q || (master_rd_dvld && fifo_empty);
    port_rd_dvld = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_rd_dvld[i] = fifo_pop && (fifo_dout == port_idx_t'(i));
    end
  end

  qdr_tag_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_tag_fifo (
    .qdr_clk   (qdr_clk),
    .qdr_rst_n (qdr_rst_n),
    .push_i    (fifo_push),
    .pop_i     (fifo_pop),
    .din_i     (grant_idx),
    .dout_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign port_ack       = grant;
  assign port_rd_data   = master_rd_data;
  assign master_addr    = addr_q;
  assign master_wr_data = wr_data_q;
  assign master_wr_be   = wr_be_q;
  assign master_wr_strb = wr_strb_q;
  assign master_rd_strb = rd_strb_q;
  assign rd_outstanding = fifo_count;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// Directed testbench for qdr_port_arbiter (2 ports, 16-deep tag FIFO).
module tb_qdr_port_arbiter;

  localparam int NP  = 2;
  localparam int AWD = 21;
  localparam int DW  = 36;
  localparam int BW  = 2;
  localparam int FD  = 16;

  logic                    qdr_clk;
  logic                    qdr_rst_n;
  logic [NP*32-1:0]        port_addr;
  logic [NP-1:0]           port_wr_strb;
  logic [NP*2*DW-1:0]      port_wr_data;
  logic [NP*2*BW-1:0]      port_wr_be;
  logic [NP-1:0]           port_rd_strb;
  logic [NP-1:0]           port_ack;
  logic [2*DW-1:0]         port_rd_data;
  logic [NP-1:0]           port_rd_dvld;
  logic [AWD-1:0]          master_addr;
  logic                    master_wr_strb;
  logic [2*DW-1:0]         master_wr_data;
  logic [2*BW-1:0]         master_wr_be;
  logic                    master_rd_strb;
  logic [2*DW-1:0]         master_rd_data;
  logic                    master_rd_dvld;
  logic                    master_ack;
  logic [$clog2(FD):0]     rd_outstanding;
  logic                    err_orphan;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [71:0] PAT_A5 = 72'hA5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [71:0] D1     = 72'h11_1111_2222_3333_4444;
  localparam logic [71:0] D0     = 72'h00_ABCD_EF01_2345_6789;

  qdr_port_arbiter #(
    .NUM_PORTS      (NP),
    .QDR_ADDR_WIDTH (AWD),
    .QDR_DATA_WIDTH (DW),
    .QDR_BW_WIDTH   (BW),
    .RD_FIFO_DEPTH  (FD)
  ) dut (
    .qdr_clk        (qdr_clk),
    .qdr_rst_n      (qdr_rst_n),
    .port_addr      (port_addr),
    .port_wr_strb   (port_wr_strb),
    .port_wr_data   (port_wr_data),
    .port_wr_be     (port_wr_be),
    .port_rd_strb   (port_rd_strb),
    .port_ack       (port_ack),
    .port_rd_data   (port_rd_data),
    .port_rd_dvld   (port_rd_dvld),
    .master_addr    (master_addr),
    .master_wr_strb (master_wr_strb),
    .master_wr_data (master_wr_data),
    .master_wr_be   (master_wr_be),
    .master_rd_strb (master_rd_strb),
    .master_rd_data (master_rd_data),
    .master_rd_dvld (master_rd_dvld),
    .master_ack     (master_ack),
    .rd_outstanding (rd_outstanding),
    .err_orphan     (err_orphan)
  );

  initial qdr_clk = 1'b0;
  always #5 qdr_clk = ~qdr_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge qdr_clk);
    #1;
  endtask

  // Called 1ns after a rising edge: reset is pulsed between edges and the
  // task returns 1ns after the first edge following release.
  task automatic pulse_reset();
    #2 qdr_rst_n = 1'b0;
    #4 qdr_rst_n = 1'b1;
    tick();
  endtask

  logic [1:0] exp_ack [4];

  initial begin
    qdr_rst_n      = 1'b0;
    port_addr      = '0;
    port_wr_strb   = '0;
    port_wr_data   = '0;
    port_wr_be     = '0;
    port_rd_strb   = '0;
    master_rd_data = '0;
    master_rd_dvld = 1'b0;
    master_ack     = 1'b1;
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;

    // Reset state
    #2;
    chk("rst_wr_strb", master_wr_strb, 1'b0);
    chk("rst_rd_strb", master_rd_strb, 1'b0);
    chk("rst_addr", master_addr, '0);
    chk("rst_ack", port_ack, 2'b00);
    chk("rst_outstanding", rd_outstanding, '0);
    chk("rst_orphan", err_orphan, 1'b0);
    #10 qdr_rst_n = 1'b1;
    tick();

    // Single-port write
    port_addr[31:0]     = 32'h100;
    port_wr_data[71:0]  = PAT_A5;
    port_wr_be[3:0]     = 4'hF;
    port_wr_strb        = 2'b01;
    #1 chk("wr_ack", port_ack, 2'b01);
    tick();
    port_wr_strb = 2'b00;
    chk("wr_master_strb", master_wr_strb, 1'b1);
    chk("wr_master_addr", master_addr, 21'h100);
    chk("wr_master_data", master_wr_data, PAT_A5);
    chk("wr_master_be", master_wr_be, 4'hF);
    chk("wr_no_rd_strb", master_rd_strb, 1'b0);
    #1 chk("wr_ack_idle", port_ack, 2'b00);
    tick();
    chk("wr_strb_pulse", master_wr_strb, 1'b0);
    chk("wr_addr_hold", master_addr, 21'h100);

    // Contention from reset: grants alternate 0,1,0,1
    pulse_reset();
    port_addr = {32'h300, 32'h200};
    port_rd_strb = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("cont_ack", port_ack, exp_ack[k]);
      tick();
      chk("cont_rd_strb", master_rd_strb, 1'b1);
      chk("cont_addr", master_addr, (k % 2 == 0) ? 21'h200 : 21'h300);
    end
    port_rd_strb = 2'b00;
    chk("cont_outstanding", rd_outstanding, 5'd4);
    for (int k = 0; k < 4; k++) begin
      master_rd_dvld = 1'b1;
      master_rd_data = 72'h5000 + 72'(k);
      #1;
      chk("cont_ret_dvld", port_rd_dvld, exp_ack[k]);
      chk("cont_ret_data", port_rd_data, 72'h5000 + 72'(k));
      tick();
    end
    master_rd_dvld = 1'b0;
    chk("cont_drained", rd_outstanding, 5'd0);

    // Routing: port1 reads, then port0; returns 10 cycles later
    port_rd_strb = 2'b10;
    #1 chk("route_ack1", port_ack, 2'b10);
    tick();
    port_rd_strb = 2'b01;
    #1 chk("route_ack0", port_ack, 2'b01);
    tick();
    port_rd_strb = 2'b00;
    chk("route_outstanding", rd_outstanding, 5'd2);
    repeat (8) tick();
    master_rd_dvld = 1'b1;
    master_rd_data = D1;
    #1;
    chk("route_dvld_p1", port_rd_dvld, 2'b10);
    chk("route_data_d1", port_rd_data, D1);
    tick();
    master_rd_data = D0;
    #1;
    chk("route_dvld_p0", port_rd_dvld, 2'b01);
    chk("route_data_d0", port_rd_data, D0);
    tick();
    master_rd_dvld = 1'b0;
    chk("route_drained", rd_outstanding, 5'd0);

    // FIFO full: reads stall, writes continue
    port_rd_strb = 2'b01;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("full_fill_ack", port_ack, 2'b01);
      tick();
    end
    chk("full_count", rd_outstanding, 5'd16);
    chk("full_rd_stall", port_ack, 2'b00);
    port_addr[63:32] = 32'h3AB;
    port_wr_strb     = 2'b10;
    #1 chk("full_wr_ack", port_ack, 2'b10);
    tick();
    port_wr_strb = 2'b00;
    chk("full_wr_strb", master_wr_strb, 1'b1);
    chk("full_wr_no_rd", master_rd_strb, 1'b0);
    chk("full_wr_addr", master_addr, 21'h3AB);
    chk("full_count_hold", rd_outstanding, 5'd16);
    #1 chk("full_stall2", port_ack, 2'b00);
    master_rd_dvld = 1'b1;
    #1;
    chk("full_pop_dvld", port_rd_dvld, 2'b01);
    chk("full_pop_still_stall", port_ack, 2'b00);
    tick();
    master_rd_dvld = 1'b0;
    chk("full_freed", rd_outstanding, 5'd15);
    #1 chk("full_pending_ack", port_ack, 2'b01);
    tick();
    port_rd_strb = 2'b00;
    chk("full_pending_rd", master_rd_strb, 1'b1);
    chk("full_refilled", rd_outstanding, 5'd16);
    master_rd_dvld = 1'b1;
    repeat (16) tick();
    master_rd_dvld = 1'b0;
    chk("full_drained", rd_outstanding, 5'd0);

    // Orphan return
    chk("orph_pre", err_orphan, 1'b0);
    master_rd_dvld = 1'b1;
    #1 chk("orph_no_dvld", port_rd_dvld, 2'b00);
    tick();
    master_rd_dvld = 1'b0;
    chk("orph_set", err_orphan, 1'b1);
    repeat (3) tick();
    chk("orph_sticky", err_orphan, 1'b1);
    pulse_reset();
    chk("orph_cleared", err_orphan, 1'b0);

    // Asynchronous reset mid-burst
    port_rd_strb = 2'b11;
    repeat (3) tick();
    chk("arst_pre_strb", master_rd_strb, 1'b1);
    chk("arst_pre_count", rd_outstanding, 5'd3);
    #2 qdr_rst_n = 1'b0;
    #1;
    chk("arst_rd_strb", master_rd_strb, 1'b0);
    chk("arst_ack", port_ack, 2'b00);
    chk("arst_count", rd_outstanding, 5'd0);
    tick();
    qdr_rst_n = 1'b1;
    tick();
    chk("arst_first_win", port_ack, 2'b01);
    tick();
    port_rd_strb = 2'b00;
    chk("arst_cmd_rd", master_rd_strb, 1'b1);
    chk("arst_cmd_addr", master_addr, 21'h200);
    chk("arst_count_after", rd_outstanding, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
